// File: rtl/axi_burst_master_pkg.sv
// axi_burst_master_pkg: shared widths, AXI encodings and FSM states for the burst master
package axi_burst_master_pkg;
   localparam int ADD_WIDTH_DEF    = 32;
   localparam int ADD_ID_WIDTH_DEF = 4;
   localparam int DATA_WIDTH_DEF   = 32;
   localparam int BURST_LEN_DEF    = 4;
   localparam int BURST_SIZE_DEF   = 3;
   localparam int BURST_TYPE_DEF   = 2;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_e;
endpackage

// File: rtl/axi_burst_master_beat_counter.sv
// axi_beat_counter: beat index of the current burst, last-beat compare and rlast mismatch detect
module axi_beat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] len_i,
   input  logic         last_i,
   output logic         at_last_o,
   output logic         mismatch_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   assign at_last_o  = cnt_q == len_i;
   assign mismatch_o = last_i != at_last_o;
endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: AXI3 initiator turning (rw, addr, len) commands plus local data streams
// into single INCR bursts, one transaction outstanding at a time.
module axi_burst_master
   import axi_burst_master_pkg::*;
#(
   parameter int ADD_WIDTH    = ADD_WIDTH_DEF,
   parameter int ADD_ID_WIDTH = ADD_ID_WIDTH_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int BURST_LEN    = BURST_LEN_DEF,
   parameter int BURST_SIZE   = BURST_SIZE_DEF,
   parameter int BURST_TYPE   = BURST_TYPE_DEF,
   parameter int MASTER_ID    = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_rw,
   input  logic [ADD_WIDTH-1:0]      cmd_addr,
   input  logic [BURST_LEN-1:0]      cmd_len,
   input  logic [DATA_WIDTH-1:0]     wr_data_in,
   input  logic [DATA_WIDTH/8-1:0]   wr_strb_in,
   input  logic                      wr_data_valid,
   output logic                      wr_data_ready,
   output logic [DATA_WIDTH-1:0]     rd_data_out,
   output logic                      rd_data_last,
   output logic                      rd_data_valid,
   input  logic                      rd_data_ready,
   output logic                      done_valid,
   output logic [1:0]                done_resp,
   output logic                      done_err,
   output logic [ADD_ID_WIDTH-1:0]   arid,
   output logic [ADD_WIDTH-1:0]      araddr,
   output logic [BURST_LEN-1:0]      arlen,
   output logic [BURST_SIZE-1:0]     arsize,
   output logic [BURST_TYPE-1:0]     arburst,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [ADD_ID_WIDTH-1:0]   rid,
   input  logic [DATA_WIDTH-1:0]     rdata,
   input  logic [1:0]                rresp,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready,
   output logic [ADD_ID_WIDTH-1:0]   awid,
   output logic [ADD_WIDTH-1:0]      awaddr,
   output logic [BURST_LEN-1:0]      awlen,
   output logic [BURST_SIZE-1:0]     awsize,
   output logic [BURST_TYPE-1:0]     awburst,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [ADD_ID_WIDTH-1:0]   wid,
   output logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH/8-1:0]   wstrb,
   output logic                      wlast,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [ADD_ID_WIDTH-1:0]   bid,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   output logic [1:0]                arlock,
   output logic [1:0]                awlock,
   output logic [3:0]                arcache,
   output logic [3:0]                awcache,
   output logic [2:0]                arprot,
   output logic [2:0]                awprot
);
   localparam logic [ADD_ID_WIDTH-1:0] MID  = ADD_ID_WIDTH'(MASTER_ID);
   localparam logic [BURST_SIZE-1:0]   SIZE = BURST_SIZE'($clog2(DATA_WIDTH / 8));
   state_e                 state_q;
   logic [ADD_WIDTH-1:0]   addr_q;
   logic [BURST_LEN-1:0]   len_q;
   logic [1:0]             resp_q;
   logic                   cmd_ready_q, arvalid_q, awvalid_q, bready_q, done_valid_q, err_q;
   logic                   rd_st, wr_st, r_beat, w_beat, at_last, mismatch;
   assign rd_st = state_q == RD_DATA;
   assign wr_st = state_q == WR_DATA;
   // R and W streams are wired straight through while their data phase is active
   assign rready        = rd_st & rd_data_ready;
   assign rd_data_valid = rd_st & rvalid;
   assign rd_data_out   = rd_st ? rdata : '0;
   assign rd_data_last  = rd_st & rlast;
   assign wvalid        = wr_st & wr_data_valid;
   assign wr_data_ready = wr_st & wready;
   assign wdata         = wr_st ? wr_data_in : '0;
   assign wstrb         = wr_st ? wr_strb_in : '0;
   assign wlast         = wr_st & at_last;
   assign r_beat        = rvalid & rready;
   assign w_beat        = wvalid & wready;
   assign cmd_ready  = cmd_ready_q;
   assign arvalid    = arvalid_q;
   assign awvalid    = awvalid_q;
   assign bready     = bready_q;
   assign done_valid = done_valid_q;
   assign done_resp  = resp_q;
   assign done_err   = err_q;
   assign araddr  = addr_q;
   assign awaddr  = addr_q;
   assign arlen   = len_q;
   assign awlen   = len_q;
   assign arid    = MID;
   assign awid    = MID;
   assign wid     = MID;
   assign arsize  = SIZE;
   assign awsize  = SIZE;
   assign arburst = BURST_TYPE'(BURST_INCR);
   assign awburst = BURST_TYPE'(BURST_INCR);
   assign arlock  = '0;
   assign awlock  = '0;
   assign arcache = '0;
   assign awcache = '0;
   assign arprot  = '0;
   assign awprot  = '0;
   axi_beat_counter #(.W(BURST_LEN)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (cmd_valid & cmd_ready_q),
      .inc_i      (r_beat | w_beat),
      .len_i      (len_q),
      .last_i     (rlast),
      .at_last_o  (at_last),
      .mismatch_o (mismatch)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         resp_q       <= RESP_OKAY;
         err_q        <= 1'b0;
         cmd_ready_q  <= 1'b1;
         arvalid_q    <= 1'b0;
         awvalid_q    <= 1'b0;
         bready_q     <= 1'b0;
         done_valid_q <= 1'b0;
      end else begin
         done_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (cmd_valid) begin
               addr_q      <= cmd_addr;
               len_q       <= cmd_len;
               resp_q      <= RESP_OKAY;
               err_q       <= 1'b0;
               cmd_ready_q <= 1'b0;
               arvalid_q   <= !cmd_rw;
               awvalid_q   <= cmd_rw;
               state_q     <= cmd_rw ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: if (arready) begin
               arvalid_q <= 1'b0;
               state_q   <= RD_DATA;
            end
            RD_DATA: if (r_beat) begin
               resp_q <= rresp > resp_q ? rresp : resp_q;
               if (rid != MID || mismatch) err_q <= 1'b1;
               // a missing rlast still ends the burst once len+1 beats have arrived
               if (rlast || at_last) begin
                  state_q      <= IDLE;
                  cmd_ready_q  <= 1'b1;
                  done_valid_q <= 1'b1;
               end
            end
            WR_ADDR: if (awready) begin
               awvalid_q <= 1'b0;
               state_q   <= WR_DATA;
            end
            WR_DATA: if (w_beat && at_last) begin
               bready_q <= 1'b1;
               state_q  <= WR_RESP;
            end
            WR_RESP: if (bvalid) begin
               resp_q <= bresp;
               if (bid != MID) err_q <= 1'b1;
               bready_q     <= 1'b0;
               cmd_ready_q  <= 1'b1;
               done_valid_q <= 1'b1;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed vector table, hand-written reset/back-to-back sequences and
// randomized bursts against a transaction-level expectation model.
module tb_axi_burst_master;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid, cmd_ready, cmd_rw;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_len;
   logic [31:0] wr_data_in;
   logic [3:0]  wr_strb_in;
   logic        wr_data_valid, wr_data_ready;
   logic [31:0] rd_data_out;
   logic        rd_data_last, rd_data_valid, rd_data_ready;
   logic        done_valid, done_err;
   logic [1:0]  done_resp;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [3:0]  arlen, awlen, wstrb;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, rresp, bresp, arlock, awlock;
   logic [3:0]  arcache, awcache;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   always #5 clk = ~clk;

   axi_burst_master dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data_in(wr_data_in), .wr_strb_in(wr_strb_in), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
      .rd_data_out(rd_data_out), .rd_data_last(rd_data_last), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
      .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arlock(arlock), .awlock(awlock), .arcache(arcache), .awcache(awcache), .arprot(arprot), .awprot(awprot)
   );

   typedef struct {
      bit          rw;
      logic [31:0] addr;
      logic [3:0]  len;
      int          rlast_at;
      bit          bad_id;
      logic [1:0]  rresp[16];
      logic [1:0]  bresp;
      logic [31:0] dat[16];
      logic [3:0]  strb[16];
      int          ar_wait;
      int          rd_wait;
      bit          bp;
      int          b_wait;
      logic [1:0]  exp_resp;
      bit          exp_err;
   } txn_t;

   int passed = 0;
   int total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic expire(input string nm);
      total++;
      $display("FAIL %s: no handshake within cycle budget, expected one", nm);
   endtask

   function automatic txn_t mk(bit rw, logic [31:0] addr, logic [3:0] len, int rlast_at, bit bad_id,
                               logic [1:0] br, int ar_wait, int rd_wait, bit bp, int b_wait,
                               logic [1:0] er, bit ee);
      txn_t t;
      t.rw = rw; t.addr = addr; t.len = len; t.rlast_at = rlast_at; t.bad_id = bad_id;
      t.bresp = br; t.ar_wait = ar_wait; t.rd_wait = rd_wait; t.bp = bp; t.b_wait = b_wait;
      t.exp_resp = er; t.exp_err = ee;
      for (int i = 0; i < 16; i++) begin
         t.rresp[i] = 2'd0;
         t.dat[i]   = $urandom;
         t.strb[i]  = 4'($urandom);
      end
      return t;
   endfunction

   // Expected outcome of a whole transaction from the protocol rules alone
   function automatic txn_t model(input txn_t t);
      int n;
      n = (t.rlast_at < int'(t.len)) ? t.rlast_at + 1 : int'(t.len) + 1;
      if (t.rw) begin
         t.exp_resp = t.bresp;
         t.exp_err  = t.bad_id;
      end else begin
         t.exp_resp = 2'd0;
         for (int i = 0; i < n; i++) if (t.rresp[i] > t.exp_resp) t.exp_resp = t.rresp[i];
         t.exp_err = t.bad_id || (t.rlast_at != int'(t.len));
      end
      return t;
   endfunction

   task automatic run_txn(input txn_t t, input bit skip_cmd, input bit hold, input txn_t nxt);
      int  k, n;
      bit  fin;
      n = (t.rlast_at < int'(t.len)) ? t.rlast_at + 1 : int'(t.len) + 1;
      if (!skip_cmd) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_rw = t.rw; cmd_addr = t.addr; cmd_len = t.len;
         #1 chk("cmd_ready_idle", cmd_ready, 1);
         @(posedge clk);
         #1 cmd_valid = hold;
         if (hold) begin cmd_rw = nxt.rw; cmd_addr = nxt.addr; cmd_len = nxt.len; end
      end
      fin = 0;
      for (int c = 0; c < 300 && !fin; c++) begin
         @(negedge clk);
         arready = !t.rw && c >= t.ar_wait;
         awready = t.rw && c >= t.ar_wait;
         wr_data_valid = 1'b1; wr_data_in = t.dat[0]; wr_strb_in = t.strb[0];
         #1;
         chk("cmd_ready_busy", cmd_ready, 0);
         if (t.rw) begin
            chk("awvalid", awvalid, 1); chk("awaddr", awaddr, t.addr); chk("awlen", awlen, t.len);
            chk("awsize", awsize, 2); chk("awburst", awburst, 1); chk("awid", awid, 0);
            chk("w_before_aw", wvalid, 0);
            fin = awready;
         end else begin
            chk("arvalid", arvalid, 1); chk("araddr", araddr, t.addr); chk("arlen", arlen, t.len);
            chk("arsize", arsize, 2); chk("arburst", arburst, 1); chk("arid", arid, 0);
            fin = arready;
         end
      end
      if (!fin) expire("addr_phase");
      k = 0; fin = 0;
      if (!t.rw) begin
         for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            arready = 1'b0; wr_data_valid = 1'b0;
            rvalid = t.bp ? 1'($urandom) : 1'b1;
            rd_data_ready = (c < t.rd_wait) ? 1'b0 : t.bp ? 1'($urandom) : 1'b1;
            rdata = t.dat[k]; rlast = (k == t.rlast_at); rresp = t.rresp[k];
            rid = (t.bad_id && k == 0) ? 4'd5 : 4'd0;
            #1;
            if (c == 0) chk("arvalid_drop", arvalid, 0);
            chk("rd_data_valid", rd_data_valid, rvalid);
            chk("rready", rready, rd_data_ready);
            if (rvalid) begin
               chk("rd_data_out", rd_data_out, t.dat[k]);
               chk("rd_data_last", rd_data_last, rlast);
            end
            if (rvalid && rd_data_ready) begin k++; fin = (k == n); end
         end
         if (!fin) expire("r_phase");
      end else begin
         for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            awready = 1'b0;
            wr_data_valid = t.bp ? 1'($urandom) : 1'b1;
            wready = t.bp ? (c % 2 == 1) : 1'b1;
            wr_data_in = t.dat[k]; wr_strb_in = t.strb[k];
            #1;
            if (c == 0) chk("awvalid_drop", awvalid, 0);
            chk("wvalid", wvalid, wr_data_valid);
            chk("wr_data_ready", wr_data_ready, wready);
            if (wvalid) begin
               chk("wdata", wdata, t.dat[k]);
               chk("wstrb", wstrb, t.strb[k]);
               chk("wlast", wlast, k == int'(t.len));
            end
            if (wr_data_valid && wready) begin k++; fin = (k == int'(t.len) + 1); end
         end
         if (!fin) expire("w_phase");
         fin = 0;
         for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            wr_data_valid = 1'b0; wready = 1'b0;
            bvalid = c >= t.b_wait; bresp = t.bresp; bid = t.bad_id ? 4'd5 : 4'd0;
            #1 chk("bready", bready, 1);
            fin = bvalid;
         end
         if (!fin) expire("b_phase");
      end
      @(negedge clk);
      bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0; rd_data_ready = 1'b0;
      #1;
      chk("done_valid", done_valid, 1);
      chk("done_resp", done_resp, t.exp_resp);
      chk("done_err", done_err, t.exp_err);
      chk("cmd_ready_done", cmd_ready, 1);
      @(negedge clk);
      #1 chk("done_pulse_end", done_valid, 0);
      if (hold) cmd_valid = 1'b0;
      else begin
         chk("done_resp_hold", done_resp, t.exp_resp);
         chk("done_err_hold", done_err, t.exp_err);
      end
   endtask

   txn_t vec[10];
   txn_t t, a, b;

   initial begin
      cmd_valid = 0; cmd_rw = 0; cmd_addr = 0; cmd_len = 0;
      wr_data_in = 0; wr_strb_in = 0; rd_data_ready = 0;
      arready = 0; awready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
      bid = 0; bresp = 0;
      wr_data_valid = 1; rvalid = 1; wready = 1; bvalid = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_rd_data_valid", rd_data_valid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_done_resp", done_resp, 0);
      chk("rst_done_err", done_err, 0);
      chk("rst_araddr", araddr, 0);
      reset = 0; wr_data_valid = 0; rvalid = 0; wready = 0; bvalid = 0;

      vec[0] = mk(0, 32'h100,  3,  3, 0, 0, 0, 0, 0, 0, 0, 0);
      vec[1] = mk(1, 32'h40,   1,  0, 0, 0, 0, 0, 0, 0, 0, 0);
      vec[2] = mk(0, 32'h200,  2,  1, 0, 0, 0, 0, 0, 0, 2, 1);
      vec[3] = mk(1, 32'h80,   0,  0, 0, 3, 0, 0, 0, 1, 3, 0);
      vec[4] = mk(0, 32'h1000, 3,  3, 0, 0, 5, 3, 1, 0, 0, 0);
      vec[5] = mk(1, 32'h2000, 3,  0, 0, 1, 5, 0, 1, 2, 1, 0);
      vec[6] = mk(0, 32'h300,  1,  1, 1, 0, 0, 0, 0, 0, 0, 1);
      vec[7] = mk(0, 32'h400,  1, 99, 0, 0, 1, 0, 0, 0, 0, 1);
      vec[8] = mk(1, 32'h500,  2,  0, 1, 0, 0, 0, 0, 0, 0, 1);
      vec[9] = mk(0, 32'h600, 15, 15, 0, 0, 0, 0, 1, 0, 0, 0);
      vec[1].dat[0] = 32'hA5A5A5A5; vec[1].dat[1] = 32'h5A5A5A5A;
      vec[1].strb[0] = 4'hF;        vec[1].strb[1] = 4'hF;
      vec[2].rresp[0] = 2'd2;
      for (int i = 0; i < 10; i++) run_txn(vec[i], 0, 0, vec[i]);

      // reset in the middle of a 4-beat write, after its first beat
      @(negedge clk);
      cmd_valid = 1; cmd_rw = 1; cmd_addr = 32'h300; cmd_len = 3;
      @(negedge clk);
      cmd_valid = 0; awready = 1;
      #1 chk("rst_seq_awvalid", awvalid, 1);
      @(negedge clk);
      awready = 0; wr_data_valid = 1; wready = 1; wr_data_in = 32'h1234; wr_strb_in = 4'hF;
      #1 chk("rst_seq_wvalid_pre", wvalid, 1);
      @(negedge clk);
      reset = 1; wr_data_in = 32'h5678;
      @(negedge clk);
      reset = 0;
      #1;
      chk("rst_seq_wvalid", wvalid, 0);
      chk("rst_seq_awvalid_low", awvalid, 0);
      chk("rst_seq_cmd_ready", cmd_ready, 1);
      chk("rst_seq_wr_data_ready", wr_data_ready, 0);
      chk("rst_seq_done_valid", done_valid, 0);
      wr_data_valid = 0; wready = 0;
      run_txn(mk(0, 32'h700, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, vec[0]);

      // back-to-back: write command waits on cmd_valid and is taken in the done cycle
      a = mk(0, 32'h800, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      b = mk(1, 32'h900, 2, 0, 0, 2, 0, 0, 0, 0, 2, 0);
      run_txn(a, 0, 1, b);
      run_txn(b, 1, 0, b);

      for (int i = 0; i < 30; i++) begin
         t = mk($urandom % 2, $urandom & 32'hFFFF_FFFC, 4'($urandom), 0, ($urandom % 8) == 0,
                2'($urandom), $urandom % 4, $urandom % 3, $urandom % 2, $urandom % 4, 0, 0);
         t.rlast_at = ($urandom % 4 == 0) ? int'($urandom % 18) : int'(t.len);
         for (int j = 0; j < 16; j++) t.rresp[j] = 2'($urandom);
         t = model(t);
         run_txn(t, 0, 0, t);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI3 initiator, the master-side counterpart of the team's memory slave; drives its AR/R/AW/W/B channels.
- Converts a simple command interface (rw, addr, len) plus local write/read data streams into single INCR bursts.
- One transaction outstanding at a time.
- Serves as the traffic engine for verif benches and for future DMA-style clients.

Parameters:
- ADD_WIDTH, 32, address width
- ADD_ID_WIDTH, 4, AXI ID width
- DATA_WIDTH, 32, data bus width (power of 2, >= 8)
- BURST_LEN, 4, arlen/awlen width
- BURST_SIZE, 3, arsize/awsize width
- BURST_TYPE, 2, arburst/awburst width
- MASTER_ID, 0, constant ID driven on arid/awid/wid

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_rw  in  1  1=write, 0=read
- cmd_addr  in  ADD_WIDTH  burst start address (size-aligned)
- cmd_len  in  BURST_LEN  beats-1
- wr_data_in  in  DATA_WIDTH  write beat data
- wr_strb_in  in  DATA_WIDTH/8  write beat strobes
- wr_data_valid / wr_data_ready  in/out  1  write stream handshake
- rd_data_out  out  DATA_WIDTH  read beat data
- rd_data_last  out  1  last read beat
- rd_data_valid / rd_data_ready  out/in  1  read stream handshake
- done_valid  out  1  one-cycle pulse at transaction end
- done_resp  out  2  worst-case response of the transaction
- done_err  out  1  protocol error (rlast/ID mismatch)
- arid, araddr, arlen, arsize, arburst, arvalid  out  per params / 1  read address channel
- arready  in  1  read address channel
- rid, rdata, rresp, rlast, rvalid  in  per params / 1  read data channel
- rready  out  1  read data channel
- awid, awaddr, awlen, awsize, awburst, awvalid  out  per params / 1  write address channel
- awready  in  1  write address channel
- wid, wdata, wstrb, wlast, wvalid  out  per params / 1  write data channel
- wready  in  1  write data channel
- bid, bresp, bvalid  in  ADD_ID_WIDTH / 2 / 1  write response channel
- bready  out  1  write response channel
- arlock/awlock (2), arcache/awcache (4), arprot/awprot (3)  out  constant 0

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- Reset: state=IDLE, beat counter=0, and every output is 0 except cmd_ready=1.
- A reset asserted mid-transaction drops all valids on the next edge; partial bursts are abandoned.
- cmd_ready=1 only in IDLE.
- On cmd_valid&&cmd_ready: latch addr, len, rw; clear the resp/err accumulators; go to RD_ADDR or WR_ADDR.
- Constant address-channel fields:
  - arsize/awsize = log2(DATA_WIDTH/8)
  - arburst/awburst = 2'b01 (INCR)
  - arid/awid/wid = MASTER_ID
- RD_ADDR: arvalid=1 (registered) and held with araddr/arlen stable until arready. On the arvalid&&arready edge, go to RD_DATA; arvalid=0 next cycle.
- RD_DATA:
  - rready = rd_data_ready; rd_data_valid = rvalid; rd_data_out = rdata; rd_data_last = rlast (all combinational).
  - Per accepted beat: beat counter +1; resp accumulator = max(acc, rresp).
  - done_err is set if rid!=MASTER_ID, rlast=1 with count!=len, or rlast=0 with count==len.
  - The burst ends on the rlast beat, or on beat count==len if rlast never comes. Then return to IDLE and pulse done_valid.
- WR_ADDR: same as RD_ADDR on the AW channel. W beats are not issued before AW is accepted.
- WR_DATA:
  - wvalid = wr_data_valid; wr_data_ready = wready; wdata/wstrb pass through.
  - wlast = (count==len).
  - The beat with wlast accepted moves the FSM to WR_RESP.
- WR_RESP: bready=1. On bvalid:
  - done_resp = bresp.
  - done_err |= (bid!=MASTER_ID).
  - Return to IDLE and pulse done_valid.
- done_valid rises one cycle after the final handshake. done_resp/done_err hold until the next accept.
- Maximum beats per burst = 2^BURST_LEN (len=0 means 1 beat). Counter width is BURST_LEN.
- 4 KB boundary crossing and address alignment are the caller's responsibility and are not checked.
- A new command can be accepted in the cycle done_valid is high. The minimum gap between commands is 1 cycle.

Decomposition:
- Shared package/include (existing param include):
  - width params
  - BURST_INCR=2'b01
  - RESP_OKAY=0, RESP_EXOKAY=1, RESP_SLVERR=2, RESP_DECERR=3
  - FSM state encodings
- Optional sub-module axi_beat_counter: counter, last-beat compare, mismatch detect. It is shared by the R and W paths.

Test Plan:
- Read, addr=0x100, len=3, slave returns 4 beats OKAY with rlast on beat 4 -> araddr=0x100, arlen=3, arsize=2, 4 beats on rd_data_*, done_valid pulse, done_resp=0, done_err=0.
- Write, addr=0x40, len=1, data 0xA5A5A5A5/0x5A5A5A5A, strb=0xF -> AW before W, wlast only on beat 2, bready until B, done_resp=bresp=0.
- Backpressure: arready/awready low 5 cycles, wready toggling, rd_data_ready low 3 cycles -> valids and data held stable, no beat lost or duplicated.
- Error: read len=2 with rlast on beat 2 and rresp=2 on beat 1 -> done_err=1, done_resp=2. Write with bresp=3 -> done_resp=3.
- Reset asserted during WR_DATA after beat 1 of 4 -> next cycle wvalid=awvalid=0, cmd_ready=1. A following read completes normally.
- Back-to-back: read then write queued with cmd_valid held -> second command accepted in the done_valid cycle.
